// File: rtl/regfile_writeback_queue_pkg.sv
// regfile_writeback_queue_pkg
// Shared constants and types for the register-file write-back queue.
//   DATA_W     : width of one register and of the write data
//   ADDR_W     : register index width
//   NUM_REGS   : number of architectural registers (width of the pending mask)
//   wb_entry_t : one queued register write {dest, data}
//   destOneHot : decodes a register index into a NUM_REGS-wide one-hot mask
package regfile_writeback_queue_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Used to build the pending mask one entry at a time.
  function automatic logic [NUM_REGS-1:0] destOneHot(input logic [ADDR_W-1:0] dest);
    destOneHot       = '0;
    destOneHot[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_writeback_queue_fifo.sv
// wb_fifo
// DEPTH-entry synchronous FIFO of register writes with two ordered write
// ports and one read port.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset, empties the FIFO
//   flush_i      : synchronous clear of pointers and count
//   wr0En_i      : write wr0Entry_i at the tail
//   wr0Entry_i   : older of the two entries written this cycle
//   wr1En_i      : write wr1Entry_i at tail+1 (only used together with wr0En_i)
//   wr1Entry_i   : younger entry written this cycle
//   rdEn_i       : retire the head entry (only asserted when count_o > 0)
//   headEntry_o  : entry at the head pointer
//   count_o      : number of occupied entries, 0..DEPTH
//   slotValid_o  : per-slot occupancy mask
//   slots_o      : raw storage, qualified by slotValid_o
module wb_fifo
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       wr0En_i,
  input  wb_entry_t                  wr0Entry_i,
  input  logic                       wr1En_i,
  input  wb_entry_t                  wr1Entry_i,
  input  logic                       rdEn_i,
  output wb_entry_t                  headEntry_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           slotValid_o,
  output wb_entry_t [DEPTH-1:0]      slots_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      tailPlusOne;
  logic [PTR_W-1:0]      offset;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  // Flush discards everything, including any write offered in the same cycle.
  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    tailPlusOne = tail_q + PTR_W'(1);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr0En_i) mem_d[tail_q]      = wr0Entry_i;
      if (wr1En_i) mem_d[tailPlusOne] = wr1Entry_i;
      if (rdEn_i)  head_d = head_q + PTR_W'(1);
      tail_d  = tail_q + PTR_W'(wr0En_i) + PTR_W'(wr1En_i);
      count_d = count_q + CNT_W'(wr0En_i) + CNT_W'(wr1En_i) - CNT_W'(rdEn_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    slotValid_o = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - head_q;
      slotValid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  assign headEntry_o = mem_q[head_q];
  assign count_o     = count_q;
  assign slots_o     = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Collects ALU and load results, keeps them in arrival order and issues at
// most one register-file write per cycle. Publishes a pending mask so decode
// can stall reads of registers that still have writes queued.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   flush        : synchronous squash of all queued writes
//   alu_valid/alu_dest/alu_result/alu_ready : ALU result handshake
//   mem_valid/mem_dest/mem_data/mem_ready   : load result handshake
//   reg_write/write_enable/wb_data          : register file write port
//   pending      : bit r set while any queued entry targets register r
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic [ADDR_W-1:0]   reg_write,
  output logic                write_enable,
  output logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] pending
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  wb_entry_t             headEntry;
  logic [DEPTH-1:0]      slotValid;
  wb_entry_t [DEPTH-1:0] slots;
  logic                  memAccept;
  logic                  aluAccept;
  logic                  headValid;
  wb_entry_t             memEntry;
  wb_entry_t             aluEntry;
  wb_entry_t             wr0Entry;

  // Readiness looks only at the registered count; the retire happening at
  // the same edge is deliberately not counted as free space. The load is the
  // older producer, so with one slot left it wins over the ALU.
  assign mem_ready = (count < CNT_W'(DEPTH));
  assign alu_ready = (count <= CNT_W'(DEPTH - 2)) |
                     ((count == CNT_W'(DEPTH - 1)) & ~mem_valid);

  // Flush drops offers even though ready is still shown to the producers.
  assign memAccept = mem_valid & mem_ready & ~flush;
  assign aluAccept = alu_valid & alu_ready & ~flush;

  assign memEntry = '{dest: mem_dest, data: mem_data};
  assign aluEntry = '{dest: alu_dest, data: alu_result};

  // Port 0 always takes the oldest accepted offer; port 1 only ever carries
  // the ALU result when a load was accepted alongside it.
  assign wr0Entry = memAccept ? memEntry : aluEntry;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (flush),
    .wr0En_i    (memAccept | aluAccept),
    .wr0Entry_i (wr0Entry),
    .wr1En_i    (memAccept & aluAccept),
    .wr1Entry_i (aluEntry),
    .rdEn_i     (headValid),
    .headEntry_o(headEntry),
    .count_o    (count),
    .slotValid_o(slotValid),
    .slots_o    (slots)
  );

  // The head is presented whenever the queue is non-empty and retires at the
  // next edge, where the register file captures it; idle outputs are zero.
  assign headValid    = (count != '0);
  assign write_enable = headValid;
  assign reg_write    = headValid ? headEntry.dest : '0;
  assign wb_data      = headValid ? headEntry.data : '0;

  // Only occupied slots contribute, so stale storage never leaks into the mask.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i]) pending = pending | destOneHot(slots[i].dest);
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue
// Scoreboard bench for regfile_writeback_queue: stimulus pushes expected
// writes into a queue, a monitor pops and compares the write port and the
// pending mask every cycle.
module tb_regfile_writeback_queue;
  import regfile_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_dest;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_ready;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_dest;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_ready;
  logic [ADDR_W-1:0]   reg_write;
  logic                write_enable;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] pending;

  wb_entry_t expQ[$];
  int        checks = 0;
  int        errors = 0;
  bit        resetActive;

  always #10 clk = ~clk;

  regfile_writeback_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_result  (alu_result),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_dest    (mem_dest),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .reg_write   (reg_write),
    .write_enable(write_enable),
    .wb_data     (wb_data),
    .pending     (pending)
  );

  // One comparison: counts it and reports a failure line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of offers, checks readiness from the model occupancy and
  // records what the queue should hold after the coming edge.
  task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat,
                               input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                               input logic fl, output logic memAcc, output logic aluAcc);
    int   freeSlots;
    logic expMemRdy;
    logic expAluRdy;
    @(negedge clk);
    mem_valid  = mv;
    mem_dest   = md;
    mem_data   = mdat;
    alu_valid  = av;
    alu_dest   = ad;
    alu_result = adat;
    flush      = fl;
    #1;
    freeSlots = DEPTH - expQ.size();
    expMemRdy = (freeSlots >= 1);
    expAluRdy = (freeSlots >= 2) || (freeSlots == 1 && !mv);
    checkOutput("mem_ready", 32'(mem_ready), 32'(expMemRdy));
    checkOutput("alu_ready", 32'(alu_ready), 32'(expAluRdy));
    memAcc = mv && expMemRdy && !fl;
    aluAcc = av && expAluRdy && !fl;
    #2;
    if (fl) expQ.delete();
    if (memAcc) expQ.push_back('{dest: md, data: mdat});
    if (aluAcc) expQ.push_back('{dest: ad, data: adat});
  endtask

  task automatic idleCycles(input int n);
    logic ma, aa;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ma, aa);
  endtask

  // Monitor: the oldest expected write must be on the port whenever the model
  // queue is non-empty; it retires at the following edge.
  initial begin : monitor
    logic [NUM_REGS-1:0] expPend;
    forever begin
      @(negedge clk);
      #2;
      if (!resetActive) begin
        expPend = '0;
        foreach (expQ[i]) expPend[expQ[i].dest] = 1'b1;
        checkOutput("pending", 32'(pending), 32'(expPend));
        if (expQ.size() > 0) begin
          checkOutput("write_enable", 32'(write_enable), 32'd1);
          checkOutput("reg_write", 32'(reg_write), 32'(expQ[0].dest));
          checkOutput("wb_data", 32'(wb_data), 32'(expQ[0].data));
          void'(expQ.pop_front());
        end else begin
          checkOutput("write_enable_idle", 32'(write_enable), 32'd0);
          checkOutput("reg_write_idle", 32'(reg_write), 32'd0);
          checkOutput("wb_data_idle", 32'(wb_data), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic            ma, aa;
    logic            mv, av, fl;
    logic [ADDR_W-1:0] md, ad;
    logic [DATA_W-1:0] mdat, adat;
    bit              holdMem, holdAlu;
    int              sent, guard;

    // Reset held with live offers: nothing may be captured or written.
    resetActive = 1'b1;
    reset      = 1'b0;
    flush      = 1'b0;
    mem_valid  = 1'b1;
    mem_dest   = 4'd9;
    mem_data   = 16'h5A5A;
    alu_valid  = 1'b1;
    alu_dest   = 4'd10;
    alu_result = 16'hA5A5;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_write_enable", 32'(write_enable), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_wb_data", 32'(wb_data), 32'd0);
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    mem_valid   = 1'b0;
    alu_valid   = 1'b0;
    reset       = 1'b1;
    resetActive = 1'b0;
    idleCycles(2);

    $display("[TB] single ALU write");
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 16'hBEEF, 1'b0, ma, aa);
    idleCycles(3);

    $display("[TB] simultaneous load and ALU to the same register");
    applyStimulus(1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, ma, aa);
    idleCycles(3);

    $display("[TB] six back-to-back ALU offers");
    sent  = 0;
    guard = 0;
    while (sent < 6 && guard < 50) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 4'(sent + 1), 16'h3000 + 16'(sent), 1'b0, ma, aa);
      if (aa) sent++;
      guard++;
    end
    checkOutput("alu_offers_accepted", 32'(sent), 32'd6);
    idleCycles(3);

    $display("[TB] both producers every cycle until full");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'(i), 16'h4000 + 16'(i), 1'b1, 4'(i + 8), 16'h4800 + 16'(i), 1'b0, ma, aa);
    idleCycles(5);

    $display("[TB] flush with three entries queued");
    applyStimulus(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, ma, aa);
    applyStimulus(1'b1, 4'd3, 16'h0303, 1'b1, 4'd4, 16'h0404, 1'b0, ma, aa);
    applyStimulus(1'b1, 4'd6, 16'h0606, 1'b1, 4'd7, 16'h0707, 1'b1, ma, aa);
    idleCycles(2);

    $display("[TB] asynchronous reset with two entries queued");
    applyStimulus(1'b1, 4'd11, 16'hCAFE, 1'b1, 4'd12, 16'hF00D, 1'b0, ma, aa);
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    #5;
    resetActive = 1'b1;
    reset       = 1'b0;
    expQ.delete();
    #1;
    checkOutput("arst_write_enable", 32'(write_enable), 32'd0);
    checkOutput("arst_pending", 32'(pending), 32'd0);
    checkOutput("arst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("arst_wb_data", 32'(wb_data), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("arst_hold_write_enable", 32'(write_enable), 32'd0);
    @(negedge clk);
    reset       = 1'b1;
    resetActive = 1'b0;
    idleCycles(2);

    $display("[TB] randomized traffic");
    holdMem = 1'b0;
    holdAlu = 1'b0;
    mv = 1'b0; md = '0; mdat = '0;
    av = 1'b0; ad = '0; adat = '0;
    repeat (400) begin
      if (!holdMem) begin
        mv   = ($urandom_range(0, 3) != 0);
        md   = 4'($urandom_range(0, 15));
        mdat = 16'($urandom);
      end
      if (!holdAlu) begin
        av   = ($urandom_range(0, 3) != 0);
        ad   = 4'($urandom_range(0, 15));
        adat = 16'($urandom);
      end
      fl = ($urandom_range(0, 31) == 0);
      applyStimulus(mv, md, mdat, av, ad, adat, fl, ma, aa);
      holdMem = mv && !ma && !fl;
      holdAlu = av && !aa && !fl;
    end
    idleCycles(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
